// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared state encoding, port indices and default bus widths
package data_mem_arbiter_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: two requester ports plus the single-port memory bus
//   requester side : reqN, weN, addrN, wdataN in; ackN, rvalidN, rdataN out
//   memory side    : mem_access_addr, mem_in, mem_write_en, mem_read_en out; mem_out in
//   slave modport is the arbiter's view, master is the requesters'/memory's view
interface data_mem_arbiter_if #(
  parameter int ADDR_W = data_mem_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = data_mem_arbiter_pkg::DEF_DATA_W
);
  logic              req0, we0, ack0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, ack1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_in, mem_out;
  logic              mem_write_en, mem_read_en;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_out,
    output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
    output mem_access_addr, mem_in, mem_write_en, mem_read_en
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_out,
    input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
    input  mem_access_addr, mem_in, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// data_mem_arbiter_rr_arb2: two-way round-robin pick with exclusion mask
//   clk, reset : clock and synchronous active-high reset
//   i_req      : per-port request
//   i_mask     : ports not allowed to win this edge (the port currently in ACCESS)
//   o_valid    : some port is eligible
//   o_grant    : winning port index; pointer moves to the other port on every grant
module data_mem_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic       o_valid,
  output logic       o_grant
);
  import data_mem_arbiter_pkg::*;
  logic       r_ptr;
  logic [1:0] w_elig;
  always_comb begin
    w_elig  = i_req & ~i_mask;
    o_valid = |w_elig;
    o_grant = &w_elig ? r_ptr : w_elig[PORT1];
  end
  always_ff @(posedge clk)
    if (reset) r_ptr <= PORT0;
    else if (o_valid) r_ptr <= ~o_grant;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between two requesters
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave view of data_mem_arbiter_if (both requesters + memory bus)
// A granted port owns the memory for exactly one ACCESS cycle; memory outputs are
// combinational from the registered state, read data is registered one cycle later.
module data_mem_arbiter #(
  parameter int ADDR_W = data_mem_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = data_mem_arbiter_pkg::DEF_DATA_W
) (
  input logic clk,
  input logic reset,
  data_mem_arbiter_if.slave bus
);
  import data_mem_arbiter_pkg::*;
  state_t            r_state, w_state_nxt;
  logic              r_gnt, w_valid, w_pick, w_access, w_we;
  logic [1:0]        w_req, w_mask, w_rd, r_rvalid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, r_rdata0, r_rdata1;
  data_mem_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .i_mask  (w_mask),
    .o_valid (w_valid),
    .o_grant (w_pick)
  );
  always_comb begin
    w_req       = {bus.req1, bus.req0};
    w_access    = r_state == ACCESS;
    // the port being served this cycle may still hold req; keep it out of the next pick
    w_mask      = {w_access & r_gnt, w_access & ~r_gnt};
    w_state_nxt = w_valid ? ACCESS : IDLE;
    w_we        = r_gnt ? bus.we1 : bus.we0;
    w_addr      = r_gnt ? bus.addr1 : bus.addr0;
    w_wdata     = r_gnt ? bus.wdata1 : bus.wdata0;
    w_rd        = {2{w_access & ~w_we}} & {r_gnt, ~r_gnt};
    bus.ack0            = w_access & (r_gnt == PORT0);
    bus.ack1            = w_access & (r_gnt == PORT1);
    bus.mem_access_addr = w_access ? w_addr : '0;
    bus.mem_in          = w_access ? w_wdata : '0;
    bus.mem_write_en    = w_access & w_we;
    bus.mem_read_en     = w_access & ~w_we;
    bus.rvalid0         = r_rvalid[PORT0];
    bus.rvalid1         = r_rvalid[PORT1];
    bus.rdata0          = r_rdata0;
    bus.rdata1          = r_rdata1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= PORT0;
    end else begin
      r_state <= w_state_nxt;
      if (w_valid) r_gnt <= w_pick;
    end
  // reset drops any read still in flight along with the held read data
  always_ff @(posedge clk)
    if (reset) begin
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd[PORT0]) r_rdata0 <= bus.mem_out;
      if (w_rd[PORT1]) r_rdata1 <= bus.mem_out;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench with a read-response scoreboard
module tb_data_mem_arbiter;
  typedef struct {
    logic        port;
    logic [15:0] data;
    int          due;
  } exp_t;
  logic        clk, reset, ld_en;
  logic [7:0]  ld_a;
  logic [15:0] ld_d;
  logic [15:0] mem [256];
  exp_t        sb [$];
  int          checks = 0, errors = 0, cyc_n = 0;
  data_mem_arbiter_if bus();
  data_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  assign bus.mem_out = mem[bus.mem_access_addr[7:0]];
  always @(posedge clk)
    if (bus.mem_write_en) mem[bus.mem_access_addr[7:0]] <= bus.mem_in;
    else if (ld_en) mem[ld_a] <= ld_d;
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (sb.size() != 0 && sb[0].due == cyc_n) begin
      e = sb.pop_front();
      chk("rvalid", {bus.rvalid1, bus.rvalid0} === (e.port ? 2'b10 : 2'b01));
      chk("rdata", (e.port ? bus.rdata1 : bus.rdata0) === e.data);
    end else
      chk("no_rvalid", {bus.rvalid1, bus.rvalid0} === 2'b00);
  endtask
  initial begin
    reset = 1; ld_en = 0; ld_a = 0; ld_d = 0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    @(negedge clk);
    ld_en = 1; ld_a = 8'h01; ld_d = 16'h1111;
    cyc();
    ld_a = 8'h02; ld_d = 16'h2222;
    cyc();
    ld_en = 0;
    chk("reset_ctl", {bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.mem_write_en, bus.mem_read_en} === 6'b0);
    chk("reset_data", {bus.rdata0, bus.rdata1, bus.mem_access_addr, bus.mem_in} === 64'b0);
    reset = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0001;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0002;
    cyc();
    chk("sim_ack0", {bus.ack1, bus.ack0, bus.mem_read_en} === 3'b011);
    chk("sim_addr0", bus.mem_access_addr === 16'h0001);
    sb.push_back('{1'b0, 16'h1111, cyc_n + 1});
    bus.req0 = 0;
    cyc();
    chk("sim_ack1", {bus.ack1, bus.ack0, bus.mem_read_en} === 3'b101);
    chk("sim_addr1", bus.mem_access_addr === 16'h0002);
    sb.push_back('{1'b1, 16'h2222, cyc_n + 1});
    bus.req1 = 0;
    cyc();
    chk("idle_en", {bus.mem_write_en, bus.mem_read_en} === 2'b00);
    chk("rdata0_held", bus.rdata0 === 16'h1111);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0005; bus.wdata0 = 16'hA5A5;
    cyc();
    chk("wr_ack0", {bus.ack0, bus.mem_write_en, bus.mem_read_en} === 3'b110);
    chk("wr_addr", bus.mem_access_addr === 16'h0005);
    chk("wr_data", bus.mem_in === 16'hA5A5);
    bus.req0 = 0;
    cyc();
    chk("wr_rdata0_kept", bus.rdata0 === 16'h1111);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0005;
    cyc();
    chk("rd_ack1", {bus.ack1, bus.mem_read_en} === 2'b11);
    sb.push_back('{1'b1, 16'hA5A5, cyc_n + 1});
    bus.req1 = 0;
    cyc();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0001;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0002;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("alt", {bus.ack1, bus.ack0} === (i[0] ? 2'b10 : 2'b01));
      sb.push_back('{i[0], (i[0] ? 16'h2222 : 16'h1111), cyc_n + 1});
    end
    bus.req0 = 0; bus.req1 = 0;
    cyc();
    cyc();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("solo", {bus.ack0, bus.mem_read_en, bus.mem_write_en} === (i[0] ? 3'b000 : 3'b110));
      if (!i[0]) sb.push_back('{1'b0, 16'h1111, cyc_n + 1});
      if (i == 5) bus.req0 = 0;
    end
    cyc();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0003; bus.wdata0 = 16'hBEEF;
    cyc();
    chk("e_ack0", {bus.ack0, bus.mem_write_en} === 2'b11);
    bus.req0 = 0;
    bus.we1 = 1; bus.addr1 = 16'h0007; bus.wdata1 = 16'hDEAD;
    bus.req1 = 1;
    #2;
    bus.req1 = 0;
    cyc();
    chk("e_no_ack1", {bus.ack1, bus.mem_write_en, bus.mem_read_en} === 3'b000);
    cyc();
    chk("e_no_ack1_b", {bus.ack1, bus.mem_write_en, bus.mem_read_en} === 3'b000);
    chk("e_mem3", mem[3] === 16'hBEEF);
    chk("e_mem7", mem[7] !== 16'hDEAD);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0002;
    cyc();
    chk("f_ack1", {bus.ack1, bus.mem_read_en} === 2'b11);
    reset = 1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0001;
    cyc();
    chk("f_rst_ctl", {bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.mem_write_en, bus.mem_read_en} === 6'b0);
    chk("f_rst_data", {bus.rdata0, bus.rdata1, bus.mem_access_addr, bus.mem_in} === 64'b0);
    reset = 0;
    cyc();
    chk("f_first0", {bus.ack1, bus.ack0} === 2'b01);
    sb.push_back('{1'b0, 16'h1111, cyc_n + 1});
    bus.req0 = 0;
    cyc();
    chk("f_then1", {bus.ack1, bus.ack0} === 2'b10);
    sb.push_back('{1'b1, 16'h2222, cyc_n + 1});
    bus.req1 = 0;
    cyc();
    cyc();
    chk("sb_empty", sb.size() == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
